// File: rtl/bsg_mem_1rw_sync_mask_write_banked_hs.sv
// Banked 1RW synchronous memory with write-mask granularity, a valid/ready
// request port, a valid/yumi read-response port and an optional post-reset
// zero-initialisation sweep. Banks are interleaved on the low address bits.
module bsg_mem_1rw_sync_mask_write_banked_hs #(
  parameter int unsigned els_p             = 512,
  parameter int unsigned data_width_p      = 64,
  parameter int unsigned mask_gran_p       = 8,
  parameter int unsigned num_banks_p       = 2,
  parameter bit          init_zero_p       = 1'b1,
  parameter bit          latch_last_read_p = 1'b1,
  localparam int unsigned addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int unsigned mask_width_lp    = data_width_p / mask_gran_p
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [data_width_p-1:0]  data_i,
  input  logic [mask_width_lp-1:0] w_mask_i,
  output logic                     v_o,
  output logic [data_width_p-1:0]  data_o,
  input  logic                     yumi_i,
  output logic                     init_done_o
);

  localparam int unsigned lg_banks_lp   = (num_banks_p > 1) ? $clog2(num_banks_p) : 0;
  localparam int unsigned bank_width_lp = (lg_banks_lp > 0) ? lg_banks_lp : 1;
  localparam int unsigned rows_lp       = els_p / num_banks_p;
  localparam int unsigned row_width_lp  = (rows_lp > 1) ? $clog2(rows_lp) : 1;
  localparam logic [row_width_lp-1:0] last_row_lp = row_width_lp'(rows_lp - 1);

  // Parameter sanity checks, evaluated at elaboration.
  if ((data_width_p % mask_gran_p) != 0) begin : g_err_gran
    $error("data_width_p must be a multiple of mask_gran_p");
  end
  if ((els_p % num_banks_p) != 0) begin : g_err_els
    $error("els_p must be a multiple of num_banks_p");
  end
  if ((num_banks_p == 0) || ((num_banks_p & (num_banks_p - 1)) != 0)) begin : g_err_banks
    $error("num_banks_p must be a power of 2");
  end

  typedef enum logic {StInit, StReady} state_e;

  state_e                  state_q, state_d;
  logic [row_width_lp-1:0] cnt_q, cnt_d;
  logic                    v_q, v_d;
  logic [data_width_p-1:0] data_q;

  logic                     req_fire, rd_fire;
  logic [bank_width_lp-1:0] req_bank;
  logic [row_width_lp-1:0]  req_row;
  logic [data_width_p-1:0]  req_bit_mask;

  logic [num_banks_p-1:0]   bank_we;
  logic [row_width_lp-1:0]  wr_row;
  logic [data_width_p-1:0]  wr_data;
  logic [data_width_p-1:0]  wr_mask;
  logic [data_width_p-1:0]  bank_rdata [num_banks_p];

  assign init_done_o = (state_q == StReady);
  // A pending response blocks every request type unless it is being consumed.
  assign ready_o     = init_done_o & (~v_q | yumi_i);
  assign req_fire    = v_i & ready_o;
  assign rd_fire     = req_fire & ~w_i;
  assign v_o         = v_q;
  assign data_o      = data_q;

  // Low address bits select the bank, the rest select the row within it.
  if (num_banks_p > 1) begin : g_bank_sel
    assign req_bank = bank_width_lp'(addr_i);
  end else begin : g_bank_sel_one
    assign req_bank = '0;
  end
  assign req_row = row_width_lp'(addr_i >> lg_banks_lp);

  // Expand each mask bit over its mask_gran_p data bits.
  always_comb begin
    req_bit_mask = '0;
    for (int k = 0; k < int'(mask_width_lp); k++) begin
      req_bit_mask[k*mask_gran_p +: mask_gran_p] = {mask_gran_p{w_mask_i[k]}};
    end
  end

  // Bank write controls: the sweep hits the same row of every bank at once,
  // normal writes enable only the addressed bank.
  always_comb begin
    bank_we = '0;
    wr_row  = req_row;
    wr_data = data_i;
    wr_mask = req_bit_mask;
    if (state_q == StInit) begin
      bank_we = '1;
      wr_row  = cnt_q;
      wr_data = '0;
      wr_mask = '1;
    end else if (req_fire && w_i) begin
      bank_we[req_bank] = 1'b1;
    end
  end

  // Synthesisable 1RW bank model; one instance per bank.
  for (genvar b = 0; b < int'(num_banks_p); b++) begin : g_bank
    logic [data_width_p-1:0] mem_q [rows_lp];

    // Masked write: unmasked bits keep their stored value.
    always_ff @(posedge clk_i) begin
      if (bank_we[b]) begin
        mem_q[wr_row] <= (mem_q[wr_row] & ~wr_mask) | (wr_data & wr_mask);
      end
    end

    assign bank_rdata[b] = mem_q[req_row];
  end

  // Sweep/state next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + row_width_lp'(1);
      if (cnt_q == last_row_lp) begin
        state_d = StReady;
        cnt_d   = '0;
      end
    end
  end

  // Response valid: set by an accepted read, cleared by yumi without a new read.
  always_comb begin
    v_d = v_q;
    if (rd_fire) begin
      v_d = 1'b1;
    end else if (yumi_i) begin
      v_d = 1'b0;
    end
  end

  // State, sweep counter and response-valid registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= init_zero_p ? StInit : StReady;
      cnt_q   <= '0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
    end
  end

  // Read data register; loads only on an accepted read so it holds while the
  // response waits for yumi.
  if (latch_last_read_p) begin : g_data_latch
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        data_q <= '0;
      end else if (rd_fire) begin
        data_q <= bank_rdata[req_bank];
      end
    end
  end else begin : g_data_nolatch
    always_ff @(posedge clk_i) begin
      if (rd_fire) begin
        data_q <= bank_rdata[req_bank];
      end
    end
  end

`ifndef SYNTHESIS
  // Protocol checks on the consumer and requester.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(yumi_i && !v_q))
        else $error("yumi_i asserted while v_o is low");
      assert (!(v_i && $isunknown(w_i)))
        else $error("v_i asserted with unknown w_i");
    end
  end
`endif

endmodule
